// File: rtl/alu_seq_driver_pkg.sv
// rtl/alu_seq_driver_pkg.sv - shared encodings for the ALU program sequencer
package alu_seq_driver_pkg;

  typedef enum logic [2:0] {
    FN_ADD_RIPPLE = 3'd0,
    FN_ADD        = 3'd1,
    FN_ORXOR      = 3'd2,
    FN_ANYSET     = 3'd3,
    FN_ALLSET     = 3'd4,
    FN_SHL        = 3'd5,
    FN_MUL        = 3'd6,
    FN_HALT       = 3'd7
  } alu_fn_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  localparam int ENTRY_OP_W = 3;
  localparam int ENTRY_B_W  = 4;

endpackage

// File: rtl/seq_prog_mem.sv
// rtl/seq_prog_mem.sv - program register file, synchronous write, asynchronous read
module seq_prog_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 7,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // No reset: program contents are meant to survive a sequencer reset.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_seq_driver.sv
// rtl/alu_seq_driver.sv - steps a stored (func, b) program through the lab ALU
module alu_seq_driver
  import alu_seq_driver_pkg::*;
#(
  parameter int PROG_DEPTH = 8,
  parameter int OP_W       = ENTRY_OP_W,
  parameter int B_W        = ENTRY_B_W,
  parameter int RES_W      = 8,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [OP_W+B_W-1:0] prog_data,
  input  logic [RES_W-1:0] alu_result,
  output logic [OP_W-1:0]  alu_func,
  output logic [B_W-1:0]   alu_b,
  output logic             alu_load,
  output logic             alu_clear,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx,
  output logic [RES_W-1:0] last_result
);

  localparam int EW = OP_W + B_W;

  seq_state_e     state, state_nx;
  logic [EW-1:0]  entry;
  logic [OP_W-1:0] entry_func;
  logic [B_W-1:0] entry_b;
  logic           drive_entry;

  seq_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && (state == S_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (step_idx),
    .rdata (entry)
  );

  assign entry_func = entry[EW-1 -: OP_W];
  assign entry_b    = entry[B_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      step_idx    <= '0;
      last_result <= '0;
    end else begin
      state <= state_nx;
      // ISSUE is entered only from CLEAR (first entry) or LOAD (next entry).
      if (state_nx == S_ISSUE) begin
        step_idx <= (state == S_CLEAR) ? '0 : step_idx + AW'(1);
      end
      if (state == S_LOAD) begin
        last_result <= alu_result;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_CLEAR;
        S_CLEAR: state_nx = S_ISSUE;
        S_ISSUE: state_nx = (entry_func == OP_W'(FN_HALT)) ? S_DONE : S_LOAD;
        S_LOAD:  state_nx = (step_idx == AW'(PROG_DEPTH - 1)) ? S_DONE : S_ISSUE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Every output decodes the state register, so strobes never see start/abort combinationally.
  assign drive_entry = (state == S_ISSUE) || (state == S_LOAD);
  assign alu_func    = drive_entry ? entry_func : '0;
  assign alu_b       = drive_entry ? entry_b : '0;
  assign alu_load    = (state == S_LOAD);
  assign alu_clear   = (state == S_CLEAR);
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_alu_seq_driver.sv
// tb/tb_alu_seq_driver.sv - self-checking bench for alu_seq_driver
module tb_alu_seq_driver;
  import alu_seq_driver_pkg::*;

  localparam int D      = 8;
  localparam int BUDGET = 30;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [6:0] prog_data = '0;
  logic [7:0] alu_result;
  logic [2:0] alu_func;
  logic [3:0] alu_b;
  logic       alu_load, alu_clear, busy, done;
  logic [2:0] step_idx;
  logic [7:0] last_result;

  always #5 clk = ~clk;

  alu_seq_driver dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .abort       (abort),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .alu_result  (alu_result),
    .alu_func    (alu_func),
    .alu_b       (alu_b),
    .alu_load    (alu_load),
    .alu_clear   (alu_clear),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx),
    .last_result (last_result)
  );

  // Behavioural lab ALU: combinational function of (func, b, register).
  function automatic logic [7:0] alu_f(input logic [2:0] f, input logic [3:0] b, input logic [7:0] r);
    case (f)
      FN_ADD_RIPPLE, FN_ADD: return r + {4'h0, b};
      FN_ORXOR:              return r ^ {4'h0, b};
      FN_ANYSET:             return r | {4'h0, b};
      FN_ALLSET:             return r & {4'hF, b};
      FN_SHL:                return (r << 1) + {4'h0, b};
      FN_MUL:                return r * {4'h0, b};
      default:               return r;
    endcase
  endfunction

  logic [7:0] alu_reg;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        alu_reg <= '0;
    else if (alu_clear) alu_reg <= '0;
    else if (alu_load)  alu_reg <= alu_result;
  end
  assign alu_result = alu_f(alu_func, alu_b, alu_reg);

  logic [6:0] shadow [D];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         obs_loads[$];
  int         obs_steps[$];
  logic [6:0] obs_fb[$];
  logic [7:0] obs_res[$];
  logic [7:0] exp_res[$];
  logic [6:0] exp_fb[$];
  int         obs_done, obs_clear, n_clear, n_done;
  logic       busy_after, busy_gap;
  logic [7:0] exp_last;

  typedef struct {
    logic [55:0] prog;
    int          n_loads;
    int          done_c;
    logic [7:0]  last;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [55:0] pk(input logic [6:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  task automatic write_entry(input int a, input logic [6:0] d);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = a[2:0];
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    shadow[a] = d;
  endtask

  task automatic load_prog(input logic [55:0] p);
    for (int i = 0; i < D; i++) write_entry(i, p[i*7 +: 7]);
  endtask

  // Start at edge 0 and record what happens in cycles 1..BUDGET (sampled mid-cycle).
  task automatic run(input int abort_cyc, input int we_from, input int we_to);
    logic pend;
    pend = 1'b0;
    obs_loads.delete(); obs_steps.delete(); obs_fb.delete(); obs_res.delete();
    obs_done = -1; obs_clear = -1; n_clear = 0; n_done = 0;
    busy_after = 1'bx; busy_gap = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (pend) begin
        obs_res.push_back(last_result);
        pend = 1'b0;
      end
      if (obs_done >= 0 && c == obs_done + 1) begin
        busy_after = busy;
        break;
      end
      if (!busy && obs_done < 0) busy_gap = 1'b1;
      if (alu_clear) begin
        n_clear++;
        if (obs_clear < 0) obs_clear = c;
      end
      if (alu_load) begin
        obs_loads.push_back(c);
        obs_steps.push_back(int'(step_idx));
        obs_fb.push_back({alu_func, alu_b});
        pend = 1'b1;
      end
      if (done) begin
        n_done++;
        if (obs_done < 0) obs_done = c;
      end
      if (abort_cyc > 0 && c == abort_cyc + 1) busy_after = busy;
      abort = (c == abort_cyc);
      prog_we = (we_from > 0 && c >= we_from && c <= we_to);
    end
    abort = 1'b0;
    prog_we = 1'b0;
  endtask

  // Reference: walk the shadow program from a cleared accumulator until HALT or the end.
  task automatic compare_run(input string tag);
    logic [7:0] acc;
    int n, exp_done;
    acc = '0;
    exp_res.delete(); exp_fb.delete();
    for (int i = 0; i < D; i++) begin
      if (shadow[i][6:4] == 3'd7) break;
      acc = alu_f(shadow[i][6:4], shadow[i][3:0], acc);
      exp_res.push_back(acc);
      exp_fb.push_back(shadow[i]);
    end
    n = exp_res.size();
    exp_done = (n < D) ? 2 * n + 3 : 2 * D + 2;
    chk({tag, ".clear_cycle"}, obs_clear, 1);
    chk({tag, ".clear_count"}, n_clear, 1);
    chk({tag, ".load_count"}, obs_loads.size(), n);
    for (int i = 0; i < n && i < obs_loads.size(); i++) begin
      chk($sformatf("%s.load%0d_cycle", tag, i), obs_loads[i], 3 + 2 * i);
      chk($sformatf("%s.load%0d_step", tag, i), obs_steps[i], i);
      chk($sformatf("%s.load%0d_funcb", tag, i), obs_fb[i], exp_fb[i]);
      if (i < obs_res.size()) chk($sformatf("%s.load%0d_result", tag, i), obs_res[i], exp_res[i]);
    end
    chk({tag, ".done_cycle"}, obs_done, exp_done);
    chk({tag, ".done_count"}, n_done, 1);
    chk({tag, ".busy_gap"}, busy_gap, 0);
    chk({tag, ".busy_after_done"}, busy_after, 0);
    if (n > 0) exp_last = exp_res[n-1];
    chk({tag, ".last_result"}, last_result, exp_last);
  endtask

  initial begin
    vt[0] = '{pk(7'h13, 7'h15, 7'h70, 7'h70, 7'h70, 7'h70, 7'h70, 7'h70), 2, 7, 8'h08};
    vt[1] = '{pk(7'h70, 7'h15, 7'h13, 7'h13, 7'h13, 7'h13, 7'h13, 7'h13), 0, 3, 8'h08};
    vt[2] = '{pk(7'h62, 7'h62, 7'h62, 7'h62, 7'h62, 7'h62, 7'h62, 7'h62), 8, 18, 8'h00};
    vt[3] = '{pk(7'h1F, 7'h51, 7'h23, 7'h70, 7'h13, 7'h13, 7'h13, 7'h13), 3, 9, 8'h1C};
    vt[4] = '{pk(7'h09, 7'h36, 7'h45, 7'h11, 7'h63, 7'h70, 7'h13, 7'h13), 5, 13, 8'h12};

    repeat (2) @(negedge clk);
    chk("reset.outputs", {alu_func, alu_b, alu_load, alu_clear, busy, done, step_idx, last_result}, 0);
    resetn = 1'b1;
    exp_last = '0;

    for (int v = 0; v < 5; v++) begin
      load_prog(vt[v].prog);
      run(0, 0, 0);
      chk($sformatf("vec%0d.n_loads", v), obs_loads.size(), vt[v].n_loads);
      chk($sformatf("vec%0d.done_cycle", v), obs_done, vt[v].done_c);
      chk($sformatf("vec%0d.last_result", v), last_result, vt[v].last);
      compare_run($sformatf("vec%0d", v));
    end

    // Abort during the second LOAD (cycle 5).
    load_prog(pk(7'h13, 7'h15, 7'h17, 7'h70, 7'h70, 7'h70, 7'h70, 7'h70));
    run(5, 0, 0);
    chk("abort.load_count", obs_loads.size(), 2);
    if (obs_res.size() >= 2) begin
      chk("abort.result0", obs_res[0], 8'h03);
      chk("abort.result1", obs_res[1], 8'h08);
    end
    chk("abort.done_count", n_done, 0);
    chk("abort.clear_count", n_clear, 1);
    chk("abort.busy_next", busy_after, 0);
    chk("abort.last_result", last_result, 8'h08);
    exp_last = 8'h08;

    // Writes while busy must be dropped.
    load_prog(vt[0].prog);
    prog_addr = 3'd1;
    prog_data = 7'h6F;
    run(0, 2, 6);
    compare_run("busywr.run1");
    run(0, 0, 0);
    compare_run("busywr.run2");

    // Asynchronous reset in the ISSUE of entry 1 (cycle 4).
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.pre_step", step_idx, 1);
    chk("rst.pre_last", last_result, 8'h03);
    #1 resetn = 1'b0;
    #1;
    chk("rst.async_outputs", {alu_func, alu_b, alu_load, alu_clear, busy, done, step_idx, last_result}, 0);
    @(negedge clk);
    resetn = 1'b1;
    exp_last = '0;
    run(0, 0, 0);
    compare_run("rst.rerun");

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < D; i++)
        write_entry(i, {3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))});
      run(0, 0, 0);
      compare_run($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
